fetch_queue: RTL and testbench

Fetch-group buffer directly downstream of the 3-wide program counter. Each cycle the PC stage presents `pc`/`valid_pc`. This block drives three instruction-memory addresses and captures the returned 3-instruction group into a small group FIFO. It presents the oldest group to decode through a valid/ready handshake, and raises `freeze_front` to stall the PC whenever the FIFO cannot accept a group.

---
 rtl/fetch_queue.sv | 134 +++++++++++++
 tb/tb_fetch_queue.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: small FIFO of 3-instruction fetch groups between the PC stage
// and decode. It drives three consecutive instruction-memory addresses from
// the presented pc, captures the returned group together with its pc, and
// offers the oldest group to decode through a valid/ready handshake.
// freeze_front stalls the PC stage whenever a group cannot be accepted.
module fetch_queue #(
    parameter int INST_W = 16,
    parameter int DEPTH  = 4     // power of 2, at least 2
) (
    input  logic                clk,
    input  logic                rst,          // asynchronous, active-low
    input  logic [7:0]          pc,
    input  logic                valid_pc,
    output logic                freeze_front,
    output logic [7:0]          imem_addr0,
    output logic [7:0]          imem_addr1,
    output logic [7:0]          imem_addr2,
    input  logic [3*INST_W-1:0] imem_rdata,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_pc,
    output logic [INST_W-1:0]   out_inst0,
    output logic [INST_W-1:0]   out_inst1,
    output logic [INST_W-1:0]   out_inst2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Queue bookkeeping; pointers wrap naturally because DEPTH is a power of 2.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic push;
    logic pop;
    logic full;
    logic empty;

    // Per-slot address and read-back buses, indexed by slot number.
    logic [2:0][7:0]        slot_addr;
    logic [2:0][INST_W-1:0] slot_rd;

    // Head-group pc storage (payload is deliberately not reset).
    logic [7:0] pc_mem [DEPTH];

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // The stall only depends on registered occupancy and flush, so decode's
    // ready never reaches back into the PC stage combinationally.
    assign freeze_front = full | flush;
    assign push         = valid_pc & ~freeze_front;
    assign out_valid    = ~empty;
    assign pop          = out_valid & out_ready & ~flush;

    // Group addresses wrap modulo 256, so pc=254 fetches 254, 255, 0.
    // Each instruction slot gets its own address adder and storage array.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_slot
            logic [INST_W-1:0] inst_mem [DEPTH];

            assign slot_addr[gi] = pc + 8'(gi);

            // Capture this slot's instruction word when a group is pushed.
            always_ff @(posedge clk) begin
                if (push) begin
                    inst_mem[wr_ptr_q] <= imem_rdata[gi*INST_W +: INST_W];
                end
            end

            assign slot_rd[gi] = inst_mem[rd_ptr_q];
        end
    endgenerate

    assign imem_addr0 = slot_addr[0];
    assign imem_addr1 = slot_addr[1];
    assign imem_addr2 = slot_addr[2];

    // Capture the group base pc alongside its instructions.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q] <= pc;
        end
    end

    // Head of queue is read straight from the entry under rd_ptr; the value
    // is meaningless while out_valid is low.
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_inst0 = slot_rd[0];
    assign out_inst1 = slot_rd[1];
    assign out_inst2 = slot_rd[2];

    // Next-state for pointers and occupancy; flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset drops every queued group at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: a PC-stage model feeds groups, a random
// instruction memory answers the fetch addresses, and a queue-of-groups
// reference model predicts what decode should see.
module tb_fetch_queue;

    localparam int INST_W = 16;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [7:0]        pc;
        logic [INST_W-1:0] i0;
        logic [INST_W-1:0] i1;
        logic [INST_W-1:0] i2;
    } grp_t;

    logic                clk;
    logic                rst;
    logic [7:0]          pc;
    logic                valid_pc;
    logic                freeze_front;
    logic [7:0]          imem_addr0;
    logic [7:0]          imem_addr1;
    logic [7:0]          imem_addr2;
    logic [3*INST_W-1:0] imem_rdata;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          out_pc;
    logic [INST_W-1:0]   out_inst0;
    logic [INST_W-1:0]   out_inst1;
    logic [INST_W-1:0]   out_inst2;

    logic [INST_W-1:0] mem [256];
    grp_t              mq [$];
    logic [7:0]        pc_r;
    logic              vpc_r;
    int                checks;
    int                errors;

    fetch_queue #(.INST_W(INST_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .valid_pc     (valid_pc),
        .freeze_front (freeze_front),
        .imem_addr0   (imem_addr0),
        .imem_addr1   (imem_addr1),
        .imem_addr2   (imem_addr2),
        .imem_rdata   (imem_rdata),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst0    (out_inst0),
        .out_inst1    (out_inst1),
        .out_inst2    (out_inst2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory.
    assign imem_rdata = {mem[imem_addr2], mem[imem_addr1], mem[imem_addr0]};

    // Advance one clock: update the reference queue from the inputs presented
    // for this edge, then move the PC stage on the following negedge.
    task automatic tick();
        logic       frz;
        logic       do_push;
        logic       do_pop;
        logic [7:0] a1;
        logic [7:0] a2;
        grp_t       g;
        frz     = (mq.size() == DEPTH) || flush;
        do_push = vpc_r && !frz;
        do_pop  = (mq.size() != 0) && out_ready && !flush;
        if (flush) begin
            mq.delete();
        end else begin
            if (do_pop) begin
                void'(mq.pop_front());
            end
            if (do_push) begin
                a1   = pc_r + 8'd1;
                a2   = pc_r + 8'd2;
                g.pc = pc_r;
                g.i0 = mem[pc_r];
                g.i1 = mem[a1];
                g.i2 = mem[a2];
                mq.push_back(g);
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (!frz) begin
            pc_r  = pc_r + 8'd3;
            vpc_r = 1'b1;
        end
        pc       = pc_r;
        valid_pc = vpc_r;
        #1;
    endtask

    // Put the DUT and the PC-stage model into reset for one cycle.
    task automatic do_reset();
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        pc_r      = 8'd253;
        vpc_r     = 1'b0;
        pc        = pc_r;
        valid_pc  = vpc_r;
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        pc_r      = 8'd253;
        vpc_r     = 1'b0;
        pc        = pc_r;
        valid_pc  = vpc_r;
        mq.delete();
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (freeze_front !== 1'b0) begin
            errors++;
            $display("FAIL reset_freeze got=%b exp=0", freeze_front);
        end
        checks++;
        if (dut.count_q !== 3'd0) begin
            errors++;
            $display("FAIL reset_count got=%0d exp=0", dut.count_q);
        end
        checks++;
        if ({imem_addr0, imem_addr1, imem_addr2} !== {8'd253, 8'd254, 8'd255}) begin
            errors++;
            $display("FAIL reset_addr got=%0d,%0d,%0d exp=253,254,255", imem_addr0, imem_addr1, imem_addr2);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (freeze_front !== 1'b1) begin
            errors++;
            $display("FAIL reset_freeze_flush got=%b exp=1", freeze_front);
        end
        flush = 1'b0;
        pc    = 8'd254;
        #1;
        checks++;
        if ({imem_addr0, imem_addr1, imem_addr2} !== {8'd254, 8'd255, 8'd0}) begin
            errors++;
            $display("FAIL addr_wrap254 got=%0d,%0d,%0d exp=254,255,0", imem_addr0, imem_addr1, imem_addr2);
        end
        pc = pc_r;
        @(negedge clk);
        rst = 1'b1;
        #1;
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    // Reset release with decode always ready: groups 0,3,6,9 one per cycle,
    // first visible one cycle after its push.
    task automatic test_stream_start();
        logic [7:0] a;
        do_reset();
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_early_valid got=%b exp=0", out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            a = 8'(3 * k);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== a) begin
                errors++;
                $display("FAIL start_pc k=%0d got valid=%b pc=%0d exp valid=1 pc=%0d", k, out_valid, out_pc, a);
            end
            checks++;
            if (out_inst0 !== mem[a] || out_inst1 !== mem[8'(a + 8'd1)] || out_inst2 !== mem[8'(a + 8'd2)]) begin
                errors++;
                $display("FAIL start_inst k=%0d got=%h,%h,%h exp=%h,%h,%h", k, out_inst0, out_inst1, out_inst2,
                         mem[a], mem[8'(a + 8'd1)], mem[8'(a + 8'd2)]);
            end
        end
        $display("test_stream_start done: checks=%0d errors=%0d", checks, errors);
    endtask

    // Fill with decode stalled, pop one, and confirm the held pc goes in once.
    task automatic test_fill();
        logic [7:0] got [5];
        int         n;
        do_reset();
        out_ready = 1'b0;
        repeat (5) tick();
        checks++;
        if (freeze_front !== 1'b1 || dut.count_q !== 3'd4) begin
            errors++;
            $display("FAIL fill_full got freeze=%b count=%0d exp freeze=1 count=4", freeze_front, dut.count_q);
        end
        checks++;
        if (pc !== 8'd12) begin
            errors++;
            $display("FAIL fill_pc got=%0d exp=12", pc);
        end
        repeat (2) tick();
        checks++;
        if (pc !== 8'd12 || dut.count_q !== 3'd4 || out_pc !== 8'd0) begin
            errors++;
            $display("FAIL fill_hold got pc=%0d count=%0d head=%0d exp pc=12 count=4 head=0", pc, dut.count_q, out_pc);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        checks++;
        if (freeze_front !== 1'b0 || dut.count_q !== 3'd3 || out_pc !== 8'd3) begin
            errors++;
            $display("FAIL fill_pop got freeze=%b count=%0d head=%0d exp freeze=0 count=3 head=3", freeze_front, dut.count_q, out_pc);
        end
        tick();
        checks++;
        if (freeze_front !== 1'b1 || dut.count_q !== 3'd4 || pc !== 8'd15) begin
            errors++;
            $display("FAIL fill_refill got freeze=%b count=%0d pc=%0d exp freeze=1 count=4 pc=15", freeze_front, dut.count_q, pc);
        end
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 5; c++) begin
            #1;
            if (out_valid === 1'b1) begin
                got[n] = out_pc;
                n++;
            end
            tick();
        end
        checks++;
        if (n != 5 || got[0] !== 8'd3 || got[1] !== 8'd6 || got[2] !== 8'd9 || got[3] !== 8'd12 || got[4] !== 8'd15) begin
            errors++;
            $display("FAIL fill_drain got n=%0d seq=%0d,%0d,%0d,%0d,%0d exp seq=3,6,9,12,15", n, got[0], got[1], got[2], got[3], got[4]);
        end
        $display("test_fill done: checks=%0d errors=%0d", checks, errors);
    endtask

    // Random decode readiness over 100 groups against the reference queue.
    task automatic test_random_stream();
        int         delivered;
        int         cyc;
        logic [7:0] exp_pc;
        do_reset();
        delivered = 0;
        cyc       = 0;
        exp_pc    = 8'd0;
        while (delivered < 100 && cyc < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (out_valid !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, mq.size() != 0);
            end
            checks++;
            if (freeze_front !== (mq.size() == DEPTH)) begin
                errors++;
                $display("FAIL rnd_freeze cyc=%0d got=%b exp=%b", cyc, freeze_front, mq.size() == DEPTH);
            end
            if (mq.size() != 0) begin
                checks++;
                if ({out_pc, out_inst0, out_inst1, out_inst2} !== {mq[0].pc, mq[0].i0, mq[0].i1, mq[0].i2}) begin
                    errors++;
                    $display("FAIL rnd_head cyc=%0d got=%0d:%h,%h,%h exp=%0d:%h,%h,%h", cyc, out_pc, out_inst0,
                             out_inst1, out_inst2, mq[0].pc, mq[0].i0, mq[0].i1, mq[0].i2);
                end
                if (out_ready) begin
                    checks++;
                    if (out_pc !== exp_pc) begin
                        errors++;
                        $display("FAIL rnd_seq n=%0d got=%0d exp=%0d", delivered, out_pc, exp_pc);
                    end
                    exp_pc = exp_pc + 8'd3;
                    delivered++;
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (delivered != 100) begin
            errors++;
            $display("FAIL rnd_timeout got=%0d exp=100", delivered);
        end
        $display("test_random_stream done: checks=%0d errors=%0d", checks, errors);
    endtask

    // Address and pc wrap through 255.
    task automatic test_wrap();
        int c;
        do_reset();
        out_ready = 1'b1;
        c = 0;
        while (!(valid_pc === 1'b1 && pc === 8'd255) && c < 200) begin
            tick();
            c++;
        end
        checks++;
        if ({imem_addr0, imem_addr1, imem_addr2} !== {8'd255, 8'd0, 8'd1}) begin
            errors++;
            $display("FAIL wrap_addr got=%0d,%0d,%0d exp=255,0,1", imem_addr0, imem_addr1, imem_addr2);
        end
        c = 0;
        while (!(out_valid === 1'b1 && out_pc === 8'd255) && c < 10) begin
            tick();
            c++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'd255 || out_inst0 !== mem[255] || out_inst1 !== mem[0] || out_inst2 !== mem[1]) begin
            errors++;
            $display("FAIL wrap_head got=%0d:%h,%h,%h exp=255:%h,%h,%h", out_pc, out_inst0, out_inst1, out_inst2,
                     mem[255], mem[0], mem[1]);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'd2) begin
            errors++;
            $display("FAIL wrap_next got valid=%b pc=%0d exp valid=1 pc=2", out_valid, out_pc);
        end
        $display("test_wrap done: checks=%0d errors=%0d", checks, errors);
    endtask

    // Flush with three groups queued and a valid group presented.
    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        repeat (4) tick();
        checks++;
        if (dut.count_q !== 3'd3 || pc !== 8'd9 || valid_pc !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup got count=%0d pc=%0d exp count=3 pc=9", dut.count_q, pc);
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (freeze_front !== 1'b1) begin
            errors++;
            $display("FAIL flush_freeze got=%b exp=1", freeze_front);
        end
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dut.count_q !== 3'd0 || freeze_front !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear got valid=%b count=%0d freeze=%b exp valid=0 count=0 freeze=0", out_valid, dut.count_q, freeze_front);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'd9 || dut.count_q !== 3'd1) begin
            errors++;
            $display("FAIL flush_after got valid=%b pc=%0d count=%0d exp valid=1 pc=9 count=1", out_valid, out_pc, dut.count_q);
        end
        $display("test_flush done: checks=%0d errors=%0d", checks, errors);
    endtask

    // Asynchronous reset between edges, then restart from pc 0.
    task automatic test_async_reset();
        int c;
        do_reset();
        out_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got=%b exp=1", out_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dut.count_q !== 3'd0) begin
            errors++;
            $display("FAIL areset_immediate got valid=%b count=%0d exp valid=0 count=0", out_valid, dut.count_q);
        end
        pc_r     = 8'd253;
        vpc_r    = 1'b0;
        pc       = pc_r;
        valid_pc = vpc_r;
        mq.delete();
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        #1;
        c = 0;
        while (out_valid !== 1'b1 && c < 10) begin
            tick();
            c++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'd0) begin
            errors++;
            $display("FAIL areset_first got valid=%b pc=%0d exp valid=1 pc=0", out_valid, out_pc);
        end
        $display("test_async_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        pc        = 8'd253;
        valid_pc  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = INST_W'($urandom);
        end
        test_reset();
        test_stream_start();
        test_fill();
        test_random_stream();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
